// File: rtl/sd_block_test_sequencer_if.sv
// User-side command/data interface of the M_SD_Card controller.
// The sequencer takes the master modport; the controller (or a model of it) takes slave.
interface sd_block_test_sequencer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              SD_Enable;
    logic              SD_we;
    logic [31:0]       SD_Addr_Block;
    logic [31:0]       SD_SerialCount;
    logic              SD_Complite;
    logic              SD_Fail;
    logic              SD_Init_Complite;
    logic              SD_Init_Fail;
    logic              SD_InPut_Data_Valid;
    logic [31:0]       SD_InPut_Data_Addr;
    logic [DATA_W-1:0] SD_InPut_Data;
    logic              SD_Out_Data_Valid;
    logic [31:0]       SD_Out_Data_Addr;
    logic [DATA_W-1:0] SD_Out_Data;

    modport master (
        output SD_Enable, SD_we, SD_Addr_Block, SD_SerialCount, SD_InPut_Data,
        input  SD_Complite, SD_Fail, SD_Init_Complite, SD_Init_Fail,
               SD_InPut_Data_Valid, SD_InPut_Data_Addr,
               SD_Out_Data_Valid, SD_Out_Data_Addr, SD_Out_Data
    );

    modport slave (
        input  SD_Enable, SD_we, SD_Addr_Block, SD_SerialCount, SD_InPut_Data,
        output SD_Complite, SD_Fail, SD_Init_Complite, SD_Init_Fail,
               SD_InPut_Data_Valid, SD_InPut_Data_Addr,
               SD_Out_Data_Valid, SD_Out_Data_Addr, SD_Out_Data
    );
endinterface

// File: rtl/sd_block_test_sequencer.sv
// Write-then-readback-compare traffic generator for M_SD_Card; pattern data is
// regenerated from the byte offset or an LFSR stream, so no buffer memory is needed.
module sd_block_test_sequencer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned MAX_BLOCKS  = 64,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic                        multi,
    input  logic [31:0]                 seed,
    input  logic [31:0]                 base_block,
    input  logic [$clog2(MAX_BLOCKS):0] num_blocks,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [2:0]                  fail_code,
    output logic [15:0]                 err_count,
    output logic [31:0]                 first_err_off,
    sd_block_test_sequencer_if.master   sd
);
    localparam int unsigned     NB_W   = $clog2(MAX_BLOCKS) + 1;
    localparam int unsigned     BYTES  = DATA_W / 8;
    localparam int unsigned     NW     = (DATA_W + 31) / 32;
    localparam logic [31:0]     TAPS   = 32'h8020_0003;
    localparam logic [NB_W-1:0] NB_ONE = NB_W'(1);

    typedef enum logic [3:0] {
        StIdle, StWaitInit, StWrCmd, StWrLow, StRdCmd, StRdLow, StCheck, StDone, StFail
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              multi_q, multi_d;
    logic [31:0]       seed_q, seed_d;
    logic [31:0]       base_q, base_d;
    logic [NB_W-1:0]   nb_q, nb_d;
    logic [NB_W-1:0]   blk_q, blk_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [31:0]       tmo_q, tmo_d;
    logic [31:0]       exp_addr_q, exp_addr_d;
    logic              order_err_q, order_err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [15:0]       err_q, err_d;
    logic [31:0]       first_off_q, first_off_d;
    logic [2:0]        fail_code_q, fail_code_d;
    logic              pass_q, pass_d;

    logic              cmd_st, wr_v, rd_v;
    logic [31:0]       blk_off, k_wr, k_rd, v_addr, bad_off, lfsr_walk;
    logic [NW*32-1:0]  lfsr_word;
    logic [DATA_W-1:0] exp_rd;
    logic [15:0]       n_bad;
    logic [16:0]       err_sum;
    logic              found;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    function automatic logic [31:0] lfsr_init(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [7:0] s8,
                                                  input logic [31:0] k,
                                                  input logic [DATA_W-1:0] lw);
        logic [DATA_W-1:0] w;
        logic [31:0]       ki;
        w = lw;
        if (m != 2'd2) begin
            for (int i = 0; i < int'(BYTES); i++) begin
                ki = k + 32'(i);
                if (m == 2'd1) w[8*i +: 8] = ki[7:0] ^ ki[15:8] ^ s8;
                else           w[8*i +: 8] = s8 + ki[7:0];
            end
        end
        return w;
    endfunction

    assign cmd_st  = (state_q == StWrCmd) || (state_q == StRdCmd);
    assign wr_v    = (state_q == StWrCmd) && sd.SD_InPut_Data_Valid;
    assign rd_v    = (state_q == StRdCmd) && sd.SD_Out_Data_Valid;
    assign blk_off = 32'(blk_q) * 32'(BLOCK_BYTES);
    assign k_wr    = sd.SD_InPut_Data_Addr + blk_off;
    assign k_rd    = sd.SD_Out_Data_Addr + blk_off;
    assign v_addr  = wr_v ? sd.SD_InPut_Data_Addr : sd.SD_Out_Data_Addr;
    assign exp_rd  = pattern(mode_q, seed_q[7:0], k_rd, lfsr_word[DATA_W-1:0]);
    assign err_sum = {1'b0, err_q} + {1'b0, n_bad};

    // Wide words take successive LFSR states, lowest lane first.
    always_comb begin
        lfsr_walk = lfsr_q;
        lfsr_word = '0;
        for (int j = 0; j < int'(NW); j++) begin
            lfsr_word[32*j +: 32] = lfsr_walk;
            lfsr_walk             = lfsr_step(lfsr_walk);
        end
    end

    always_comb begin
        n_bad   = '0;
        bad_off = '0;
        found   = 1'b0;
        for (int i = 0; i < int'(BYTES); i++) begin
            if (sd.SD_Out_Data[8*i +: 8] != exp_rd[8*i +: 8]) begin
                n_bad = n_bad + 16'd1;
                if (!found) begin
                    bad_off = k_rd + 32'(i);
                    found   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        multi_d     = multi_q;
        seed_d      = seed_q;
        base_d      = base_q;
        nb_d        = nb_q;
        blk_d       = blk_q;
        lfsr_d      = lfsr_q;
        tmo_d       = cmd_st ? tmo_q + 32'd1 : '0;
        exp_addr_d  = cmd_st ? exp_addr_q : '0;
        order_err_d = order_err_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        first_off_d = first_off_q;
        fail_code_d = fail_code_q;
        pass_d      = pass_q;

        if (wr_v || rd_v) begin
            lfsr_d     = lfsr_walk;
            exp_addr_d = v_addr + 32'(BYTES);
            if (v_addr != exp_addr_q) order_err_d = 1'b1;
        end
        if (wr_v) wdata_d = pattern(mode_q, seed_q[7:0], k_wr, lfsr_word[DATA_W-1:0]);
        if (rd_v && (n_bad != '0)) begin
            err_d = err_sum[16] ? 16'hffff : err_sum[15:0];
            if (err_q == '0) first_off_d = bad_off;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d      = mode;
                    multi_d     = multi;
                    seed_d      = seed;
                    base_d      = base_block;
                    nb_d        = (num_blocks == '0) ? NB_ONE : num_blocks;
                    blk_d       = '0;
                    lfsr_d      = lfsr_init(seed);
                    order_err_d = 1'b0;
                    err_d       = '0;
                    first_off_d = '0;
                    fail_code_d = '0;
                    pass_d      = 1'b0;
                    state_d     = StWaitInit;
                end
            end
            StWaitInit: begin
                if (sd.SD_Init_Fail) begin
                    fail_code_d = 3'd1;
                    state_d     = StFail;
                end else if (sd.SD_Init_Complite) begin
                    state_d = StWrCmd;
                end
            end
            StWrCmd, StRdCmd: begin
                if (sd.SD_Fail) begin
                    fail_code_d = 3'd2;
                    state_d     = StFail;
                end else if (sd.SD_Complite) begin
                    if (order_err_d) begin
                        fail_code_d = 3'd5;
                        state_d     = StFail;
                    end else begin
                        state_d = (state_q == StWrCmd) ? StWrLow : StRdLow;
                    end
                end else if (tmo_q == 32'(TIMEOUT - 1)) begin
                    fail_code_d = 3'd3;
                    state_d     = StFail;
                end
            end
            StWrLow, StRdLow: begin
                if (!sd.SD_Complite) begin
                    if (!multi_q && (blk_q != nb_q - NB_ONE)) begin
                        blk_d   = blk_q + NB_ONE;
                        state_d = (state_q == StWrLow) ? StWrCmd : StRdCmd;
                    end else begin
                        blk_d   = '0;
                        lfsr_d  = lfsr_init(seed_q);
                        state_d = (state_q == StWrLow) ? StRdCmd : StCheck;
                    end
                end
            end
            StCheck: begin
                if (err_q == '0) begin
                    pass_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    fail_code_d = 3'd4;
                    state_d     = StFail;
                end
            end
            StDone, StFail: state_d = StIdle;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            multi_q     <= 1'b0;
            seed_q      <= '0;
            base_q      <= '0;
            nb_q        <= '0;
            blk_q       <= '0;
            lfsr_q      <= 32'd1;
            tmo_q       <= '0;
            exp_addr_q  <= '0;
            order_err_q <= 1'b0;
            wdata_q     <= '0;
            err_q       <= '0;
            first_off_q <= '0;
            fail_code_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            multi_q     <= multi_d;
            seed_q      <= seed_d;
            base_q      <= base_d;
            nb_q        <= nb_d;
            blk_q       <= blk_d;
            lfsr_q      <= lfsr_d;
            tmo_q       <= tmo_d;
            exp_addr_q  <= exp_addr_d;
            order_err_q <= order_err_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            first_off_q <= first_off_d;
            fail_code_q <= fail_code_d;
            pass_q      <= pass_d;
        end
    end

    // Command strobes decode straight from state so an async reset drops them at once.
    assign sd.SD_Enable      = cmd_st;
    assign sd.SD_we          = (state_q == StWrCmd);
    assign sd.SD_Addr_Block  = base_q + 32'(blk_q);
    assign sd.SD_SerialCount = multi_q ? (32'(nb_q) - 32'd1) : '0;
    assign sd.SD_InPut_Data  = wdata_q;

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone) || (state_q == StFail);
    assign pass          = pass_q;
    assign fail_code     = fail_code_q;
    assign err_count     = err_q;
    assign first_err_off = first_off_q;
endmodule

// File: doc/sd_block_test_sequencer.md
Name: sd_block_test_sequencer

Overview:
- Synthesizable self-checking traffic generator for M_SD_Card. Runs write-then-readback-compare passes over a configurable range of blocks.
- Pattern data is regenerated on the fly, so no block RAM is needed. The expected value is computed from the transfer byte offset, or from an LFSR stream.
- Sits beside M_SD_Card in board-level bring-up and regression. It supersedes the bench-only sequencer, which handled fixed 1024-byte, 32-bit, incrementing-pattern transfers only.

Parameters:
- DATA_W, 32, controller data word width in bits; must be a multiple of 8.
- BLOCK_BYTES, 512, bytes per SD block.
- MAX_BLOCKS, 64, upper bound on num_blocks; sets counter widths.
- TIMEOUT, 1000000, clk cycles allowed per command before declaring a timeout.

Ports:
- clk  in  1  single clock for the block and the controller user interface.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- mode  in  2  pattern select: 0 = incrementing, 1 = xor-fold, 2 = LFSR, 3 = reserved (treated as 0).
- multi  in  1  1 = one multi-block command per pass; 0 = one command per block.
- seed  in  32  pattern seed.
- base_block  in  32  first SD block address.
- num_blocks  in  clog2(MAX_BLOCKS)+1  block count; 0 is treated as 1.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  result of the last run; held until the next start.
- fail_code  out  3  0 = ok, 1 = init fail, 2 = cmd fail, 3 = timeout, 4 = data mismatch, 5 = address order error.
- err_count  out  16  saturating count of mismatched bytes.
- first_err_off  out  32  byte offset of the first mismatch.
- SD_Enable  out  1  command enable to the controller.
- SD_we  out  1  write enable to the controller.
- SD_Addr_Block  out  32  start block of the current command.
- SD_SerialCount  out  32  number of additional blocks in the command.
- SD_Complite  in  1  command complete.
- SD_Fail  in  1  command failed.
- SD_Init_Complite  in  1  controller initialisation complete.
- SD_Init_Fail  in  1  controller initialisation failed.
- SD_InPut_Data_Valid  in  1  controller requests a write word.
- SD_InPut_Data_Addr  in  32  byte offset of the requested write word.
- SD_InPut_Data  out  DATA_W  registered write word.
- SD_Out_Data_Valid  in  1  read word valid.
- SD_Out_Data_Addr  in  32  byte offset of the read word.
- SD_Out_Data  in  DATA_W  read word.

Behaviour:
- Reset: all outputs are 0, pass = 0, state = IDLE, LFSR = 1.
- States and transitions:
  - IDLE: on start, latch all config inputs, clear err_count, first_err_off and fail_code, set busy, go to WAIT_INIT.
  - WAIT_INIT: SD_Init_Fail -> FAIL(1); SD_Init_Complite -> WR_CMD. SD_Init_Fail has priority when both are asserted.
  - WR_CMD: drive SD_we = 1, SD_Enable = 1, and SD_Addr_Block = base_block + blk. SD_SerialCount = num_blocks-1 when multi = 1, else 0.
    - SD_Fail -> FAIL(2); SD_Fail wins over SD_Complite.
    - SD_Complite -> drop SD_Enable/SD_we and go to WR_LOW.
    - Timeout counter reaching TIMEOUT -> FAIL(3).
  - WR_LOW: wait for SD_Complite = 0. Then, if multi = 0 and blocks remain, increment blk and return to WR_CMD. Otherwise reset blk and the LFSR and go to RD_CMD.
  - RD_CMD / RD_LOW: same as WR_CMD / WR_LOW with SD_we = 0. After the last block go to CHECK.
  - CHECK: err_count == 0 -> DONE; otherwise FAIL(4).
  - DONE: pass = 1, done pulse for 1 cycle, go to IDLE.
  - FAIL(code): pass = 0, fail_code = code, done pulse for 1 cycle, go to IDLE.
- Byte offset k: SD_*_Data_Addr + blk*BLOCK_BYTES. The controller address already spans all blocks of a multi command; per-block commands restart it at 0.
- Byte i of a word is bits [8i+7:8i], at offset k+i.
  - mode 0: byte = (seed[7:0] + k)[7:0].
  - mode 1: byte = k[7:0] ^ k[15:8] ^ seed[7:0].
  - mode 2: word = LFSR state (32-bit Galois, taps 0x80200003). The LFSR is seeded with seed, or 1 if seed = 0, at the start of each pass. It advances once per valid word, and words wider than 32 bits concatenate successive LFSR states.
- Write path: SD_InPut_Data updates on the cycle after SD_InPut_Data_Valid and holds otherwise.
- Read path: each SD_Out_Data_Valid compares all bytes.
  - err_count adds the number of mismatched bytes and saturates at 0xFFFF.
  - first_err_off is set on the first mismatch only.
- Addresses must arrive in order. Each valid Data_Addr must equal the previous one + DATA_W/8, starting at 0 per command. A violation sets fail_code 5 and forces the run to end in FAIL(5) after the command completes.
- Valid strobes outside WR_CMD/RD_CMD are ignored.
- start while busy is ignored.
- Asynchronous rst mid-run returns to IDLE with the reset values; SD_Enable drops immediately.

Test Plan:
- Default parameters, mode 0, seed 0, num_blocks 2, multi 1: writes byte k = k[7:0] for offsets 0..1023, one command with SerialCount 1; ends with done, pass = 1, err_count = 0.
- mode 2, seed 0, multi 0, num_blocks 3: three write commands then three read commands at base_block, +1, +2; first word written = 0x00000001; pass = 1.
- Slave corrupts read byte offset 300 (bit flip): err_count = 1, first_err_off = 300, fail_code = 4, pass = 0.
- Controller asserts SD_Fail during the second write command: SD_Enable drops the next cycle, fail_code = 2, no read command is issued.
- Controller never completes, TIMEOUT = 100: FAIL(3) after 100 cycles; start while busy has no effect; rst mid-WR_CMD drives SD_Enable to 0 immediately.
- Read addresses arrive out of order (0, 8, 4): fail_code = 5 after SD_Complite; SD_Init_Fail in WAIT_INIT gives fail_code = 1.
